// File: rtl/data_sram_resp.sv
// data_sram_resp: word-addressed RAM with byte strobes plus a memory-mapped free-running timer.
// Define DATA_SRAM_WLOG_EN to add a registered log of every mapped write.
module data_sram_resp #(
    parameter int unsigned ADDR_BITS  = 14,
    parameter logic [31:0] RAM_BASE   = 32'h1c00_0000,
    parameter logic [31:0] TIMER_ADDR = 32'hbfaf_e000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_err
`ifdef DATA_SRAM_WLOG_EN
    ,
    output logic        wlog_valid,
    output logic [31:0] wlog_addr,
    output logic [3:0]  wlog_we,
    output logic [31:0] wlog_data
`endif
);
    logic [31:0] mem [2**ADDR_BITS];
    logic [31:0] rdata_q, rdata_d, timer_q, timer_d, tmr_merge;
    logic err_q, err_d, ram_hit, tmr_hit, rd, wr, addr_unused;
    logic [ADDR_BITS-1:0] idx;

    // RAM_BASE is aligned to the window size, so a tag compare is a full range check
    assign ram_hit     = data_sram_addr[31:ADDR_BITS+2] == RAM_BASE[31:ADDR_BITS+2];
    assign tmr_hit     = data_sram_addr[31:2] == TIMER_ADDR[31:2];
    assign idx         = data_sram_addr[ADDR_BITS+1:2];
    assign rd          = data_sram_en && data_sram_we == 4'h0;
    assign wr          = data_sram_en && data_sram_we != 4'h0;
    assign addr_unused = ^data_sram_addr[1:0];

    always_comb begin
        tmr_merge = timer_q;
        for (int i = 0; i < 4; i++)
            if (data_sram_we[i]) tmr_merge[8*i +: 8] = data_sram_wdata[8*i +: 8];
        timer_d = (wr && tmr_hit) ? tmr_merge : timer_q + 32'd1;
        rdata_d = !rd ? rdata_q : ram_hit ? mem[idx] : tmr_hit ? timer_q : 32'h0;
        err_d   = data_sram_en && !ram_hit && !tmr_hit;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            timer_q <= 32'h0;
        end else begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    // RAM contents survive reset; resetn only blocks writes
    always_ff @(posedge clk) begin
        if (resetn && wr && ram_hit)
            for (int i = 0; i < 4; i++)
                if (data_sram_we[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end

    assign data_sram_rdata = rdata_q;
    assign data_sram_err   = err_q;

`ifdef DATA_SRAM_WLOG_EN
    logic        wlog_valid_q;
    logic [31:0] wlog_addr_q, wlog_data_q;
    logic [3:0]  wlog_we_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wlog_valid_q <= 1'b0;
            wlog_addr_q  <= 32'h0;
            wlog_we_q    <= 4'h0;
            wlog_data_q  <= 32'h0;
        end else begin
            wlog_valid_q <= wr && (ram_hit || tmr_hit);
            if (wr && (ram_hit || tmr_hit)) begin
                wlog_addr_q <= data_sram_addr;
                wlog_we_q   <= data_sram_we;
                wlog_data_q <= data_sram_wdata;
            end
        end
    end

    assign wlog_valid = wlog_valid_q;
    assign wlog_addr  = wlog_addr_q;
    assign wlog_we    = wlog_we_q;
    assign wlog_data  = wlog_data_q;
`endif
endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: directed requests push hand-computed {rdata, err} into a queue; a monitor checks each one a cycle later.
module tb_data_sram_resp;
    localparam logic [31:0] TMR = 32'hbfaf_e000;
    localparam logic [31:0] A   = 32'h1c00_0000;
    localparam logic [31:0] B   = 32'h1c00_fffc;
    localparam logic [31:0] C   = 32'h1c00_0008;
    localparam logic [31:0] W   = 32'h1c00_0004;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr, wdata, rdata;
    logic        err;
`ifdef DATA_SRAM_WLOG_EN
    logic        wlog_valid;
    logic [31:0] wlog_addr, wlog_data;
    logic [3:0]  wlog_we;
`endif

    data_sram_resp dut (
        .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata),
        .data_sram_rdata(rdata), .data_sram_err(err)
`ifdef DATA_SRAM_WLOG_EN
        , .wlog_valid(wlog_valid), .wlog_addr(wlog_addr), .wlog_we(wlog_we), .wlog_data(wlog_data)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [31:0] q_rd[$];
    logic        q_er[$];
    string       q_nm[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_er, input string nm);
        @(negedge clk);
        en = e; we = w; addr = a; wdata = d;
        q_rd.push_back(exp_rd);
        q_er.push_back(exp_er);
        q_nm.push_back(nm);
    endtask

    // async reset asserted mid-cycle while a write to A is being presented
    task automatic rst_pulse(input string nm);
        @(negedge clk);
        en = 1'b1; we = 4'hf; addr = A; wdata = 32'h9999_9999;
        #2 resetn = 1'b0;
        #1;
        check({nm, "_rdata"}, rdata, 32'h0);
        check({nm, "_err"}, {31'h0, err}, 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        en = 1'b0; we = 4'h0;
    endtask

    logic [31:0] m_rd;
    logic        m_er;
    string       m_nm;
    always @(posedge clk) begin
        if (q_rd.size() > 0) begin
            m_rd = q_rd.pop_front();
            m_er = q_er.pop_front();
            m_nm = q_nm.pop_front();
            #1;
            check({m_nm, "_rdata"}, rdata, m_rd);
            check({m_nm, "_err"}, {31'h0, err}, {31'h0, m_er});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b1; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
        #1 resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        req(1, 4'hf, W, 32'h1234_5678, 32'h0, 0, "wr_word");
        req(1, 4'h0, W, 32'h0, 32'h1234_5678, 0, "rd_word");
        req(1, 4'h2, W, 32'haabb_ccdd, 32'h1234_5678, 0, "wr_strb");
        req(1, 4'h0, W, 32'h0, 32'h1234_cc78, 0, "rd_strb");

        req(1, 4'hf, TMR, 32'hffff_fffe, 32'h1234_cc78, 0, "tmr_wr");
        req(0, 4'h0, 32'h0, 32'h0, 32'h1234_cc78, 0, "idle_hold");
        req(1, 4'h0, TMR, 32'h0, 32'hffff_ffff, 0, "tmr_rd");
        req(1, 4'h0, TMR, 32'h0, 32'h0, 0, "tmr_wrap");

        req(1, 4'h0, W, 32'h0, 32'h1234_cc78, 0, "rd_pre_unm");
        req(1, 4'h0, 32'h0, 32'h0, 32'h0, 1, "unm_rd");
        req(0, 4'h0, 32'h0, 32'h0, 32'h0, 0, "unm_pulse_end");
        req(1, 4'h0, W, 32'h0, 32'h1234_cc78, 0, "rd_again");
        req(1, 4'hf, 32'h1c01_0004, 32'hdead_beef, 32'h1234_cc78, 1, "unm_wr_top");
        req(1, 4'hf, 32'h0, 32'hcafe_f00d, 32'h1234_cc78, 1, "unm_wr_zero");
        req(1, 4'h0, W, 32'h0, 32'h1234_cc78, 0, "unm_no_alias");

        req(1, 4'hf, A, 32'h1111_1111, 32'h1234_cc78, 0, "wr_a");
        req(1, 4'hf, B, 32'h2222_2222, 32'h1234_cc78, 0, "wr_b_last");
        req(1, 4'hf, C, 32'h3333_3333, 32'h1234_cc78, 0, "wr_c");
        req(1, 4'h0, A, 32'h0, 32'h1111_1111, 0, "stream_a");
        req(1, 4'h0, B, 32'h0, 32'h2222_2222, 0, "stream_b");
        req(1, 4'h0, C, 32'h0, 32'h3333_3333, 0, "stream_c");
        req(0, 4'h0, 32'h0, 32'h0, 32'h3333_3333, 0, "stream_hold1");
        req(0, 4'h0, 32'h0, 32'h0, 32'h3333_3333, 0, "stream_hold2");

        req(1, 4'h0, A, 32'h0, 32'h1111_1111, 0, "rd_pre_rst");
        rst_pulse("rst_mid_a");
        req(1, 4'h0, TMR, 32'h0, 32'h1, 0, "tmr_after_rst");
        req(1, 4'h0, A, 32'h0, 32'h1111_1111, 0, "no_wr_in_rst");
        req(1, 4'h0, 32'h4, 32'h0, 32'h0, 1, "unm_pre_rst");
        rst_pulse("rst_mid_b");
        req(1, 4'h0, A, 32'h0, 32'h1111_1111, 0, "rd_after_rst2");

        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("queue_drained", q_rd.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
